// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, round count, rcon constants and small word helpers.
package aes_pkg;
  localparam int         AES_KEY_W = 128;
  localparam int         AES_NR    = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  typedef logic [31:0]          aes_word_t;
  typedef logic [AES_KEY_W-1:0] aes_key_t;

  // Left byte rotation: {a0,a1,a2,a3} -> {a1,a2,a3,a0}.
  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? RCON_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, shared by the key schedule and the cipher datapath.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  // Row-major table: entry 0 occupies the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s_o = SBOX_TBL[{~a_i, 3'b000} +: 8];
endmodule

// File: rtl/aes_key_sched.sv
// On-the-fly AES-128 key expansion running in lockstep with the round controller.
// Optional: define AES_KEY_ZEROIZE_EN to clear key_q after the round-10 key is consumed.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int KEY_W = AES_KEY_W,
  parameter int NR    = AES_NR
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [3:0]       rndNo,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] round_key,
  output logic             key_busy,
  output logic             key_err
);
  aes_key_t   key_q, key_d;
  logic [7:0] rcon_q, rcon_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  aes_key_t   src_s, next_key_s;
  logic [7:0] rc_s;
  aes_word_t  rot_s, sub_s, t_s;
  aes_word_t  w0_s, w1_s, w2_s, w3_s;

  logic       is_load_s;

  assign is_load_s = (rndNo == 4'd0);

  // Round 0 expands straight from the cipher key so round 1 is ready on the next edge.
  assign src_s = is_load_s ? aes_key_t'(key_in) : key_q;
  assign rc_s  = is_load_s ? RCON_INIT : rcon_q;
  assign rot_s = rot_word(src_s[31:0]);

  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_sbox u_sbox (
      .a_i (rot_s[8*i +: 8]),
      .s_o (sub_s[8*i +: 8])
    );
  end

  assign t_s        = sub_s ^ {rc_s, 24'h000000};
  assign w0_s       = src_s[127:96] ^ t_s;
  assign w1_s       = src_s[95:64]  ^ w0_s;
  assign w2_s       = src_s[63:32]  ^ w1_s;
  assign w3_s       = src_s[31:0]   ^ w2_s;
  assign next_key_s = {w0_s, w1_s, w2_s, w3_s};

  always_comb begin
    key_d  = key_q;
    rcon_d = rcon_q;
    busy_d = busy_q;
    err_d  = err_q;
    if (start) begin
      if (is_load_s) begin
        key_d  = next_key_s;
        rcon_d = xtime(RCON_INIT);
        busy_d = 1'b1;
      end else if (rndNo < 4'(NR)) begin
        key_d  = next_key_s;
        rcon_d = xtime(rcon_q);
      end else if (rndNo == 4'(NR)) begin
        rcon_d = RCON_INIT;
        busy_d = 1'b0;
`ifdef AES_KEY_ZEROIZE_EN
        key_d  = '0;
`else
        key_d  = key_q;
`endif
      end else begin
        err_d = 1'b1;
      end
    end else begin
      key_d = key_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      key_q  <= '0;
      rcon_q <= RCON_INIT;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      key_q  <= key_d;
      rcon_q <= rcon_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign round_key = is_load_s ? key_in : KEY_W'(key_q);
  assign key_busy  = busy_q;
  assign key_err   = err_q;
endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench: GF(2^8)-derived S-box and word-level FIPS-197 expansion model.
module tb_aes_key_sched;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   rndNo = 4'd0;
  logic [127:0] key_in = 128'h0;
  logic [127:0] round_key;
  logic         key_busy;
  logic         key_err;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  aes_key_sched dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .rndNo     (rndNo),
    .key_in    (key_in),
    .round_key (round_key),
    .key_busy  (key_busy),
    .key_err   (key_err)
  );

  always #5 clk = ~clk;

  // S-box built from the field inverse plus the affine map, independent of any table.
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Round key n of cipher key k via the 44-word expansion.
  function automatic logic [127:0] rk(input logic [127:0] k, input int n);
    logic [31:0] w [44];
    logic [7:0]  rc [10];
    logic [31:0] t;
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/4-1], 24'h000000};
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  // Model state: key loaded at round 0, number of expansions held (0 = register cleared).
  logic [127:0] m_base = 128'h0;
  int           m_n    = 0;
  logic         m_busy = 1'b0;
  logic         m_err  = 1'b0;
  logic         m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rstn) begin
      m_n     <= 0;
      m_busy  <= 1'b0;
      m_err   <= 1'b0;
      m_valid <= 1'b1;
    end else if (start) begin
      if (rndNo == 4'd0) begin
        m_base <= key_in;
        m_n    <= 1;
        m_busy <= 1'b1;
      end else if (rndNo <= 4'd9) begin
        if (m_n > 0 && m_n < 10) m_n <= m_n + 1;
      end else if (rndNo == 4'd10) begin
        m_busy <= 1'b0;
`ifdef AES_KEY_ZEROIZE_EN
        m_n    <= 0;
`endif
      end else begin
        m_err <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every negedge: compare outputs against the model.
  always @(negedge clk) begin
    logic [127:0] exp_rk;
    if (m_valid) begin
      if (rndNo == 4'd0) exp_rk = key_in;
      else if (m_n == 0) exp_rk = 128'h0;
      else exp_rk = rk(m_base, m_n);
      check("model_round_key", round_key, exp_rk);
      check("model_key_busy", {127'h0, key_busy}, {127'h0, m_busy});
      check("model_key_err", {127'h0, key_err}, {127'h0, m_err});
    end
  end

  task automatic drive(input logic rs, input logic st, input logic [3:0] rn);
    @(posedge clk);
    #1;
    rstn  = rs;
    start = st;
    rndNo = rn;
    @(negedge clk);
    #1;
  endtask

  task automatic run_block(input logic [127:0] k);
    key_in = k;
    for (int r = 0; r <= 10; r++) begin
      drive(1'b1, 1'b1, 4'(r));
      if (r == 0) check("round0_is_key_in", round_key, k);
      if (r == 1 && k == K1) check("fips_round1", round_key, K1_R1);
      if (r == 10 && k == K1) check("fips_round10", round_key, K1_R10);
      if (r == 10 && k == K2) check("k2_round10", round_key, K2_R10);
      if (r >= 1) check("busy_in_sequence", {127'h0, key_busy}, {127'h0, 1'b1});
    end
  endtask

  initial begin
    logic [127:0] after10;
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
    key_in = K1;

    // Reset state
    drive(1'b0, 1'b0, 4'd0);
    drive(1'b1, 1'b0, 4'd0);
    check("reset_busy", {127'h0, key_busy}, 128'h0);
    check("reset_err", {127'h0, key_err}, 128'h0);
    check("reset_round0_key_in", round_key, K1);
    check("reset_rcon", {120'h0, dut.rcon_q}, 128'h01);
    drive(1'b1, 1'b0, 4'd3);
    check("reset_key_q_zero", round_key, 128'h0);

    // Full FIPS-197 run, then idle at round 10
    run_block(K1);
    drive(1'b1, 1'b0, 4'd10);
`ifdef AES_KEY_ZEROIZE_EN
    after10 = 128'h0;
`else
    after10 = K1_R10;
`endif
    check("post_round10_key_q", round_key, after10);
    check("post_round10_busy", {127'h0, key_busy}, 128'h0);

    // Stall three cycles at round 4
    for (int r = 0; r <= 3; r++) drive(1'b1, 1'b1, 4'(r));
    for (int s = 0; s < 3; s++) drive(1'b1, 1'b0, 4'd4);
    for (int r = 4; r <= 10; r++) drive(1'b1, 1'b1, 4'(r));
    check("stall_round10", round_key, K1_R10);
    drive(1'b1, 1'b0, 4'd0);

    // Reset at round 6, then rerun from scratch
    for (int r = 0; r <= 5; r++) drive(1'b1, 1'b1, 4'(r));
    drive(1'b0, 1'b1, 4'd6);
    drive(1'b1, 1'b0, 4'd0);
    check("midreset_busy", {127'h0, key_busy}, 128'h0);
    check("midreset_rcon", {120'h0, dut.rcon_q}, 128'h01);
    check("midreset_key_q", dut.key_q, 128'h0);
    run_block(K1);

    // Back-to-back second block with a different key
    run_block(K2);
    drive(1'b1, 1'b0, 4'd10);
`ifdef AES_KEY_ZEROIZE_EN
    after10 = 128'h0;
`else
    after10 = K2_R10;
`endif
    check("k2_post_round10", round_key, after10);

    // Out-of-range round number sets the sticky error, key_q untouched
    drive(1'b1, 1'b1, 4'd12);
    drive(1'b1, 1'b0, 4'd10);
    check("err_set", {127'h0, key_err}, 128'h1);
    check("err_key_q_held", round_key, after10);
    run_block(K1);
    drive(1'b1, 1'b0, 4'd2);
    check("err_sticky", {127'h0, key_err}, 128'h1);
    drive(1'b0, 1'b0, 4'd0);
    drive(1'b1, 1'b0, 4'd0);
    check("err_cleared_by_reset", {127'h0, key_err}, 128'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/aes_key_sched.md
Name: aes_key_sched

Overview:
On-the-fly AES-128 key expansion unit that runs in lockstep with the AES round controller (rndNo/start).
- Supplies the round key for the round currently indicated by rndNo to the AES datapath's AddRoundKey stage.
- Derives each next round key from the previous one, one expansion per advancing cycle, so no 11x128-bit key table is stored.
- Sits directly beside the controller; consumes its rndNo and start, and feeds the core.

Parameters:
- KEY_W, 128, key/round-key width in bits; only 128 is supported.
- NR, 10, number of rounds; only 10 is supported (AES-128).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rstn  input  1  synchronous active-low reset.
- start  input  1  advance enable; same signal that steps the round controller.
- rndNo  input  4  current round number from the controller, 0..10.
- key_in  input  KEY_W  cipher key; sampled only when start=1 and rndNo=0.
- round_key  output  KEY_W  round key for the current rndNo, to AddRoundKey.
- key_busy  output  1  high while an expansion sequence is in progress (rounds 1..10).
- key_err  output  1  sticky flag: an rndNo > 10 was seen while start=1.

Behaviour:
- Reset (rstn=0 at a clock edge):
  - key_q=0, rcon_q=8'h01, key_busy=0, key_err=0.
  - round_key then follows its combinational rule; with rndNo=0 it equals key_in.
- round_key is combinational:
  - rndNo==0 -> key_in (round-0 key is the cipher key, zero latency).
  - otherwise -> key_q.
- Expansion function f(K, rc), for K = w0|w1|w2|w3 with w0 the MSBs:
  - t = SubWord(RotWord(w3)) ^ {rc, 24'h0}.
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - RotWord is a left byte rotation.
- rcon update: xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1b : 8'h00).
- Clocked updates, only when start=1:
  - rndNo==0: key_q <= f(key_in, 8'h01); rcon_q <= 8'h02; key_busy <= 1.
  - rndNo in 1..9: key_q <= f(key_q, rcon_q); rcon_q <= xtime(rcon_q). Round 9 uses rc=8'h36.
  - rndNo==10: key_q holds; rcon_q <= 8'h01; key_busy <= 0.
  - rndNo in 11..15: key_err <= 1; key_q and rcon_q hold.
- start=0: all state holds, and round_key stays stable for the current rndNo.
- Latency: the key for round r is valid in the same cycle rndNo=r, because it was computed on the edge that advanced rndNo to r.
- key_in changes after the round-0 sample are ignored until the next rndNo==0 with start=1.
- Back-to-back blocks: after round 10 the controller wraps rndNo to 0, and round_key=key_in again; the new key may differ from the previous block's key.
- Reset mid-sequence: all state returns to reset values. The controller is reset by the same rstn, so both restart from round 0 together.
- key_err clears only on reset.

Optional Feature:
- Macro: AES_KEY_ZEROIZE_EN.
- Defined:
  - On start=1 with rndNo==10, key_q <= 0, clearing the final round key from the register after its use. This limits key residency for side-channel hardening.
  - round_key then reads 0 for rndNo values 1..10 until the next load, which is unreachable in normal lockstep operation.
- Undefined: key_q holds the round-10 key, as specified above.

Decomposition:
- Shared package aes_pkg holds:
  - constants AES_KEY_W=128, AES_NR=10, RCON_INIT=8'h01, RCON_POLY=8'h1b;
  - typedef aes_word_t (32-bit) and aes_key_t (128-bit);
  - functions rot_word and xtime.
- One sub-module: aes_sbox, a combinational 8-bit S-box with 256 entries. Instantiate it 4x for SubWord; the datapath S-box shares the same module.

Test Plan:
- FIPS-197 vector: key_in=2b7e151628aed2a6abf7158809cf4f3c, rndNo 0..10 with start=1 each cycle.
  - rndNo=0 -> round_key = key_in.
  - rndNo=1 -> a0fafe1788542cb123a339392a6c7605.
  - rndNo=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
  - key_busy high for rndNo 1..10.
- Stall: same run with start deasserted for 3 cycles at rndNo=4 -> round_key is unchanged during the stall, and rounds 5..10 still match FIPS-197.
- Reset at rndNo=6 (rstn=0 for one edge) -> key_q=0, rcon_q=01, key_busy=0. A new run then reproduces the full vector from round 0.
- Back-to-back: second block with key_in=000102030405060708090a0b0c0d0e0f -> round 10 = 13111d7fe3944a17f307a78b4d2b30c5. Confirms rcon re-initialises to 01.
- Force rndNo=12 with start=1 -> key_err=1 and stays 1 until reset; key_q is unchanged.
- With AES_KEY_ZEROIZE_EN: after start at rndNo=10, key_q reads 0. Without the macro, key_q holds d014f9a8c9ee2589e13f0cc8b6630ca6.
